mem_requester: RTL and testbench
================================

Name: mem_requester

Overview:
- Initiator (master) for the 4-bit-address / 32-bit-data req/ready memory protocol.
- Accepts single read or write commands on a valid/ready command port and drives them to a memory responder.
- Holds each request until the responder returns ready, then returns a one-cycle response carrying the read data, or a timeout flag.
- Sits between a local command source (test sequencer or CPU-side logic) and the memory responder.

Parameters:
ADDR_W, 4, request address width
DATA_W, 32, data width
TIMEOUT, 32, max REQ cycles without ready before abort (legal range 2..255)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  asynchronous active-high reset
cmd_valid_i  input  1  command present
cmd_ready_o  output  1  block can accept a command this cycle
cmd_rnw_i  input  1  1 = read, 0 = write
cmd_addr_i  input  ADDR_W  command address
cmd_wdata_i  input  DATA_W  write data (ignored for reads)
req_o  output  1  memory request, held until accepted
req_rnw_o  output  1  registered copy of cmd_rnw_i
req_addr_o  output  ADDR_W  registered address
req_wdata_o  output  DATA_W  registered write data
req_ready_i  input  1  responder ready; transfer completes on a clock edge with req_o & req_ready_i
req_rdata_i  input  DATA_W  responder read data, valid in the completing cycle
rsp_valid_o  output  1  one-cycle response pulse, no backpressure
rsp_rnw_o  output  1  type of the completed command
rsp_rdata_o  output  DATA_W  captured read data; 0 for writes and timeouts
rsp_timeout_o  output  1  qualifies rsp_valid_o; command aborted without ready

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - req_o, req_rnw_o, req_addr_o, req_wdata_o, rsp_valid_o, rsp_rnw_o, rsp_rdata_o, rsp_timeout_o and wait_cnt all go to 0.
  - An in-flight request is dropped with no response.
- FSM states:
  - IDLE: cmd_ready_o=1, req_o=0. On cmd_valid_i, capture rnw/addr/wdata into the req_* registers and go to REQ; wait_cnt<=0.
  - REQ: cmd_ready_o=0, req_o=1. req_rnw_o, req_addr_o and req_wdata_o are stable for the whole state.
    - On an edge with req_ready_i=1: go to GAP; rsp_rdata_o <= req_rnw_o ? req_rdata_i : 0; rsp_timeout_o<=0.
    - Otherwise, if wait_cnt==TIMEOUT-1: go to GAP; rsp_rdata_o<=0; rsp_timeout_o<=1.
    - Otherwise: wait_cnt increments.
  - GAP: req_o=0, cmd_ready_o=0, rsp_valid_o=1 for exactly this cycle. Unconditionally go to IDLE.
    - Guarantees req_o is low for at least one cycle between requests, so the responder always sees a fresh rising edge.
- Ready vs timeout:
  - If ready and timeout coincide on the same edge, ready wins (normal completion).
  - req_ready_i is ignored outside REQ.
- Timing:
  - cmd_ready_o is combinational from state.
  - req_o is high the cycle after command acceptance.
  - The minimum command-to-command interval is 3 cycles (IDLE, REQ, GAP) when ready is already high in the first REQ cycle.
  - Maximum time in REQ is TIMEOUT cycles.
- Output holding:
  - rsp_rnw_o, rsp_rdata_o and rsp_timeout_o hold their values until the next completion.
  - req_* data registers hold their last values after the transfer.
- Widths:
  - wait_cnt is 8 bits.
  - Write data and read data pass through unmodified; no byte enables.

Test Plan:
- Write then read: cmd write addr 4'h3 data 32'hDEADBEEF, then read addr 4'h3 against the responder model → two rsp pulses; the read response has rsp_rdata_o=32'hDEADBEEF, rsp_rnw_o=1, rsp_timeout_o=0.
- Stall: responder holds req_ready_i=0 for 9 cycles, then 1 → req_o high for exactly 10 cycles with addr/wdata stable; rsp_valid_o asserts the next cycle.
- Timeout: TIMEOUT=32, req_ready_i tied 0 → req_o high for 32 cycles, then drops; rsp_valid_o=1 with rsp_timeout_o=1 and rsp_rdata_o=0; cmd_ready_o=1 one cycle later.
- Back-to-back: cmd_valid_i held high with 16 commands and req_ready_i tied 1 → a command is accepted every 3 cycles; req_o shows the 1,0,0 pattern; 16 responses in order.
- Reset mid-REQ: assert reset on the 4th REQ cycle → req_o=0 immediately (async), no rsp_valid_o; after release, cmd_ready_o=1 and a new read completes normally.
- Ready/timeout tie: req_ready_i rises exactly when wait_cnt==TIMEOUT-1 → normal completion, rsp_timeout_o=0, read data captured.

Source files
------------

// File: rtl/mem_requester.sv
// mem_requester: initiator for the req/ready memory protocol.
// Takes one read or write command at a time from a valid/ready command
// port, holds it on the request bus until the responder answers or the
// wait budget runs out, and reports the result with a one-cycle pulse.
module mem_requester #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_rnw_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              req_o,
  output logic              req_rnw_o,
  output logic [ADDR_W-1:0] req_addr_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              req_ready_i,
  input  logic [DATA_W-1:0] req_rdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_rnw_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Last wait count before the request is abandoned.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [7:0]        r_wait_cnt;
  logic              r_req_rnw;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_wdata;
  logic              r_rsp_rnw;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_timeout;
  logic              w_in_idle;
  logic              w_in_req;
  logic              w_in_gap;

  // Handshake outputs decode straight from state so reset clears them at once.
  always_comb begin
    w_in_idle = (r_state == S_IDLE);
    w_in_req  = (r_state == S_REQ);
    w_in_gap  = (r_state == S_GAP);
  end

  assign cmd_ready_o   = w_in_idle;
  assign req_o         = w_in_req;
  assign rsp_valid_o   = w_in_gap;
  assign req_rnw_o     = r_req_rnw;
  assign req_addr_o    = r_req_addr;
  assign req_wdata_o   = r_req_wdata;
  assign rsp_rnw_o     = r_rsp_rnw;
  assign rsp_rdata_o   = r_rsp_rdata;
  assign rsp_timeout_o = r_rsp_timeout;

  // Sequencer: accept, hold request until ready or timeout, then one gap cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_req_rnw     <= 1'b0;
      r_req_addr    <= '0;
      r_req_wdata   <= '0;
      r_rsp_rnw     <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_req_rnw   <= cmd_rnw_i;
            r_req_addr  <= cmd_addr_i;
            r_req_wdata <= cmd_wdata_i;
            r_wait_cnt  <= '0;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          // Ready is checked first so a ready on the last allowed cycle still completes.
          if (req_ready_i) begin
            r_rsp_rnw     <= r_req_rnw;
            r_rsp_rdata   <= r_req_rnw ? req_rdata_i : '0;
            r_rsp_timeout <= 1'b0;
            r_state       <= S_GAP;
          end else if (r_wait_cnt == LP_LAST_WAIT) begin
            r_rsp_rnw     <= r_req_rnw;
            r_rsp_rdata   <= '0;
            r_rsp_timeout <= 1'b1;
            r_state       <= S_GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: randomized self-checking bench for mem_requester.
// A responder memory answers requests after a chosen delay; a separate
// reference memory predicts each response from the command alone.
module tb_mem_requester;

  localparam int TO = 32;

  logic        clk;
  logic        reset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_rnw_i;
  logic [3:0]  cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        req_o;
  logic        req_rnw_o;
  logic [3:0]  req_addr_o;
  logic [31:0] req_wdata_o;
  logic        req_ready_i;
  logic [31:0] req_rdata_i;
  logic        rsp_valid_o;
  logic        rsp_rnw_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_timeout_o;

  logic [31:0] respMem [16];
  logic [31:0] refMem  [16];
  int          errCount;
  int          checkCount;

  mem_requester #(.ADDR_W(4), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_rnw_i     (cmd_rnw_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .req_o         (req_o),
    .req_rnw_o     (req_rnw_o),
    .req_addr_o    (req_addr_o),
    .req_wdata_o   (req_wdata_o),
    .req_ready_i   (req_ready_i),
    .req_rdata_i   (req_rdata_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_rnw_o     (rsp_rnw_o),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_timeout_o (rsp_timeout_o)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One command; the responder raises ready on REQ cycle 'delay' (never if delay >= TO).
  task automatic applyStimulus(input logic rnw, input logic [3:0] addr, input logic [31:0] wdata, input int delay);
    bit          done;
    int          n;
    logic [31:0] expData;
    done    = (delay < TO);
    n       = done ? delay + 1 : TO;
    expData = (done && rnw) ? refMem[addr] : 32'h0;
    if (done && !rnw) refMem[addr] = wdata;
    @(negedge clk);
    checkOutput("idleReady", cmd_ready_o, 1);
    checkOutput("idleReqLow", req_o, 0);
    cmd_valid_i = 1'b1;
    cmd_rnw_i   = rnw;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    req_ready_i = 1'b0;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_rnw_i   = $urandom;
    cmd_addr_i  = $urandom;
    cmd_wdata_i = $urandom;
    for (int c = 0; c < n; c++) begin
      checkOutput("reqHigh", req_o, 1);
      checkOutput("reqRnw", req_rnw_o, rnw);
      checkOutput("reqAddr", req_addr_o, addr);
      checkOutput("reqWdata", req_wdata_o, wdata);
      checkOutput("busyNotReady", cmd_ready_o, 0);
      checkOutput("noRspInReq", rsp_valid_o, 0);
      req_ready_i = (c == delay);
      req_rdata_i = (c == delay) ? respMem[req_addr_o] : $urandom;
      if (c == delay && !req_rnw_o) respMem[req_addr_o] = req_wdata_o;
      @(negedge clk);
    end
    req_ready_i = $urandom;
    req_rdata_i = $urandom;
    checkOutput("gapRspValid", rsp_valid_o, 1);
    checkOutput("gapReqLow", req_o, 0);
    checkOutput("gapNotReady", cmd_ready_o, 0);
    checkOutput("rspRnw", rsp_rnw_o, rnw);
    checkOutput("rspRdata", rsp_rdata_o, expData);
    checkOutput("rspTimeout", rsp_timeout_o, !done);
    @(negedge clk);
    checkOutput("pulseOneCycle", rsp_valid_o, 0);
    checkOutput("readyAfterGap", cmd_ready_o, 1);
    checkOutput("holdRdata", rsp_rdata_o, expData);
    checkOutput("holdTimeout", rsp_timeout_o, !done);
    req_ready_i = 1'b0;
  endtask

  // Back-to-back commands with valid held high and ready tied high.
  task automatic applyBackToBack(input int count);
    logic        rnw;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expData;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    req_ready_i = 1'b1;
    for (int i = 0; i < count; i++) begin
      rnw     = $urandom;
      addr    = $urandom;
      wdata   = $urandom;
      expData = rnw ? refMem[addr] : 32'h0;
      if (!rnw) refMem[addr] = wdata;
      cmd_rnw_i   = rnw;
      cmd_addr_i  = addr;
      cmd_wdata_i = wdata;
      checkOutput("b2bIdleReady", cmd_ready_o, 1);
      checkOutput("b2bIdleReq", req_o, 0);
      @(negedge clk);
      checkOutput("b2bReq", req_o, 1);
      checkOutput("b2bAddr", req_addr_o, addr);
      req_rdata_i = respMem[req_addr_o];
      if (!req_rnw_o) respMem[req_addr_o] = req_wdata_o;
      @(negedge clk);
      checkOutput("b2bRspValid", rsp_valid_o, 1);
      checkOutput("b2bGapReq", req_o, 0);
      checkOutput("b2bRnw", rsp_rnw_o, rnw);
      checkOutput("b2bRdata", rsp_rdata_o, expData);
      checkOutput("b2bTimeout", rsp_timeout_o, 0);
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    req_ready_i = 1'b0;
  endtask

  // Test sequence: reset, directed cases, random traffic, summary.
  initial begin
    logic [31:0] v;
    int          d;
    errCount    = 0;
    checkCount  = 0;
    reset       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_rnw_i   = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    req_ready_i = 1'b0;
    req_rdata_i = '0;
    for (int i = 0; i < 16; i++) begin
      v          = $urandom;
      respMem[i] = v;
      refMem[i]  = v;
    end
    repeat (2) @(negedge clk);
    checkOutput("rstReq", req_o, 0);
    checkOutput("rstRspValid", rsp_valid_o, 0);
    checkOutput("rstCmdReady", cmd_ready_o, 1);
    checkOutput("rstReqAddr", req_addr_o, 0);
    checkOutput("rstReqWdata", req_wdata_o, 0);
    checkOutput("rstRspRdata", rsp_rdata_o, 0);
    checkOutput("rstRspTimeout", rsp_timeout_o, 0);
    reset = 1'b0;

    $display("[TB] write then read");
    applyStimulus(1'b0, 4'h3, 32'hDEADBEEF, 1);
    applyStimulus(1'b1, 4'h3, 32'h0, 0);
    checkOutput("wrRdData", rsp_rdata_o, 32'hDEADBEEF);

    $display("[TB] stall of 9 cycles");
    applyStimulus(1'b1, 4'h7, 32'h12345678, 9);

    $display("[TB] timeout");
    applyStimulus(1'b1, 4'h2, 32'h0, 1000);
    applyStimulus(1'b0, 4'h9, 32'hCAFEF00D, 1000);

    $display("[TB] ready and timeout on the same edge");
    applyStimulus(1'b1, 4'h3, 32'h0, TO - 1);
    checkOutput("tieData", rsp_rdata_o, 32'hDEADBEEF);

    $display("[TB] back-to-back");
    applyBackToBack(16);

    $display("[TB] reset during request");
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_rnw_i   = 1'b1;
    cmd_addr_i  = 4'h5;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("preRstReq", req_o, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncReqLow", req_o, 0);
    checkOutput("asyncNoRsp", rsp_valid_o, 0);
    checkOutput("asyncCmdReady", cmd_ready_o, 1);
    checkOutput("asyncAddrClr", req_addr_o, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("postRstNoRsp", rsp_valid_o, 0);
      checkOutput("postRstReady", cmd_ready_o, 1);
    end
    applyStimulus(1'b1, 4'h5, 32'h0, 2);

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       d = TO - 1;
        1:       d = TO + $urandom_range(0, 5);
        default: d = $urandom_range(0, 5);
      endcase
      applyStimulus(1'($urandom), 4'($urandom), $urandom, d);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
